axis_tx_narrow_64to8: RTL

Native replacement for the vendor width converter between the 64-bit TX AXI-Stream FIFO and the 8-bit `axis_gmii_tx` input in `eth_mac_1g`. It accepts 64-bit beats with byte qualifiers and serializes them to one byte per accepted transfer, least-significant byte first. Bytes whose qualifier is clear are dropped. `tlast` and `tuser` are moved onto the final emitted byte of each frame. Sustained throughput is one byte per clock, and back-to-back input beats are accepted with no idle output cycle.

---
 rtl/axis_tx_narrow_64to8.sv | 103 ++++++++++
 1 files changed

// File: rtl/axis_tx_narrow_64to8.sv
// 64-to-8 AXI-Stream narrower: keep-qualified bytes out LSB first, tlast/tuser moved to the final byte.
// Latency: first byte of a beat is valid the cycle after the beat is accepted; one byte per clock sustained.
// Backpressure: holds output stable while m_axis_tready is low; takes the next beat as the last byte leaves.
module axis_tx_narrow_64to8 #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [USER_WIDTH-1:0] s_axis_tuser,
    output logic [7:0]            m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  keep_error
);

    localparam int IDX_W = $clog2(KEEP_WIDTH);

    logic [DATA_WIDTH-1:0] word_q, word_d;
    logic [KEEP_WIDTH-1:0] mask_q, mask_d;
    logic                  last_q, last_d;
    logic [USER_WIDTH-1:0] user_q, user_d;
    logic                  keep_err_q, keep_err_d;

    logic             loaded;
    logic             one_left;
    logic [IDX_W-1:0] sel_idx;
    logic             m_hs;
    logic             s_hs;

    assign loaded   = (mask_q != '0);
    assign one_left = loaded && ((mask_q & (mask_q - KEEP_WIDTH'(1))) == '0);

    always_comb begin
        sel_idx = '0;
        for (int i = KEEP_WIDTH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign m_axis_tdata  = word_q[{sel_idx, 3'b000} +: 8];
    assign m_axis_tvalid = loaded;
    assign m_axis_tlast  = last_q & one_left;
    assign m_axis_tuser  = m_axis_tlast ? user_q : '0;
    assign keep_error    = keep_err_q;

    // Refill only when empty or when the final byte is leaving this very cycle.
    assign s_axis_tready = aresetn & (~loaded | (m_axis_tready & one_left));

    assign m_hs = m_axis_tvalid & m_axis_tready;
    assign s_hs = s_axis_tvalid & s_axis_tready;

    always_comb begin
        word_d     = word_q;
        mask_d     = mask_q;
        last_d     = last_q;
        user_d     = user_q;
        keep_err_d = 1'b0;
        if (m_hs) begin
            mask_d = mask_q & (mask_q - KEEP_WIDTH'(1));
        end
        if (s_hs) begin
            word_d = s_axis_tdata;
            mask_d = s_axis_tkeep;
            last_d = s_axis_tlast;
            user_d = s_axis_tlast ? s_axis_tuser : '0;
            // An empty closing beat still has to carry tlast, so emit a single flagged 0x00 byte.
            if (s_axis_tlast && (s_axis_tkeep == '0)) begin
                word_d     = '0;
                mask_d     = KEEP_WIDTH'(1);
                user_d[0]  = 1'b1;
                keep_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            word_q     <= '0;
            mask_q     <= '0;
            last_q     <= 1'b0;
            user_q     <= '0;
            keep_err_q <= 1'b0;
        end else begin
            word_q     <= word_d;
            mask_q     <= mask_d;
            last_q     <= last_d;
            user_q     <= user_d;
            keep_err_q <= keep_err_d;
        end
    end

endmodule
